// File: rtl/tmux_pkg.sv
// Shared types and helpers for the temporal N-way multiplexer.
package tmux_pkg;

  // Widest gamma count (256 clocks) and widest channel index (32 channels).
  localparam int TMUX_TW_MAX    = 8;
  localparam int TMUX_IDX_W_MAX = 5;

  // Gamma-cycle arrival time at its widest.
  typedef logic [TMUX_TW_MAX-1:0] gtime_t;

  // Index of the lowest set bit. Returns 0 for an all-zero vector; callers
  // only use the result when at least one bit is set.
  function automatic int lowest_set(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/edge_timestamp.sv
// One temporal line: rising-edge detect, first-arrival timestamp and arrived flag.
module edge_timestamp
  import tmux_pkg::*;
#(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          grst,
  input  logic          i_line,
  input  logic          i_en,     // edges may be captured at this gcnt
  input  logic          i_clr,    // gamma boundary: forget this cycle's arrival
  input  logic [TW-1:0] i_gcnt,
  output logic          o_arrived,
  output logic [TW-1:0] o_time
);

  logic          r_prev;
  logic          r_arrived;
  logic [TW-1:0] r_time;
  logic          w_set;

  // Only the first edge of a gamma cycle is kept; later edges are ignored.
  assign w_set = i_line & ~r_prev & i_en & ~r_arrived;

  // Previous sample always tracks the line; the arrival capture wins over the boundary clear.
  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      r_prev    <= 1'b0;
      r_arrived <= 1'b0;
      r_time    <= '0;
    end else begin
      r_prev <= i_line;
      if (w_set) begin
        r_arrived <= 1'b1;
        r_time    <= i_gcnt;
      end else if (i_clr) begin
        r_arrived <= 1'b0;
      end
    end
  end

  assign o_arrived = r_arrived;
  assign o_time    = r_time;

endmodule

// File: rtl/temporal_mux_n.sv
// Temporal N-way multiplexer: each channel whose first edge in the gamma
// cycle coincides with the select line's first edge drives its y bit.
// Optional macro TMUX_PULSE_OUT_EN turns y into PULSE_WIDTH-clock pulses.
module temporal_mux_n
  import tmux_pkg::*;
#(
  parameter int NUM_INPUTS        = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic                          clk,
  input  logic                          grst,
  input  logic [NUM_INPUTS-1:0]         inputs,
  input  logic                          select_line,
  output logic [NUM_INPUTS-1:0]         y,
  output logic                          match_valid,
  output logic [$clog2(NUM_INPUTS)-1:0] match_idx,
  output logic                          gamma_start
);

  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH);
  localparam int IW = $clog2(NUM_INPUTS);

  logic                           r_started;
  logic [TW-1:0]                  r_gcnt;
  logic                           w_wrap;
  logic                           w_en;

  logic [NUM_INPUTS-1:0]          w_arr;
  logic [NUM_INPUTS-1:0][TW-1:0]  w_time;
  logic                           w_sel_arr;
  logic [TW-1:0]                  w_sel_time;

  logic [NUM_INPUTS-1:0]          w_match;
  logic [NUM_INPUTS-1:0]          w_hit_next;
  logic [31:0]                    w_hit_ext;
  logic [NUM_INPUTS-1:0]          r_hit;
  logic                           r_mv;
  logic [IW-1:0]                  r_idx;

  // The edge on which gcnt == GAMMA_CYCLE_WIDTH-1 is the boundary.
  assign w_wrap = r_started && (r_gcnt == TW'(GAMMA_CYCLE_WIDTH - 1));
  // Edges this late could not finish a match before the boundary.
  assign w_en   = r_started && (r_gcnt < TW'(GAMMA_CYCLE_WIDTH - 2));

  // Gamma counter; the first edge after reset opens cycle 0 without counting.
  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      r_started <= 1'b0;
      r_gcnt    <= '0;
    end else if (!r_started) begin
      r_started <= 1'b1;
    end else begin
      r_gcnt <= r_gcnt + 1'b1;
    end
  end

  assign gamma_start = r_started && (r_gcnt == '0);

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_ch
    edge_timestamp #(.TW(TW)) u_ch (
      .clk       (clk),
      .grst      (grst),
      .i_line    (inputs[gi]),
      .i_en      (w_en),
      .i_clr     (w_wrap),
      .i_gcnt    (r_gcnt),
      .o_arrived (w_arr[gi]),
      .o_time    (w_time[gi])
    );
  end

  edge_timestamp #(.TW(TW)) u_sel (
    .clk       (clk),
    .grst      (grst),
    .i_line    (select_line),
    .i_en      (w_en),
    .i_clr     (w_wrap),
    .i_gcnt    (r_gcnt),
    .o_arrived (w_sel_arr),
    .o_time    (w_sel_time)
  );

  // Channel matches need both arrivals; a missing arrival never matches.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_match[i] = w_arr[i] & w_sel_arr & (w_time[i] == w_sel_time);
    end
    w_hit_next = w_wrap ? '0 : (r_hit | w_match);
    w_hit_ext  = '0;
    w_hit_ext[NUM_INPUTS-1:0] = w_hit_next;
  end

  // Sticky match state; index captured on the first match of the cycle.
  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      r_hit <= '0;
      r_mv  <= 1'b0;
      r_idx <= '0;
    end else begin
      r_hit <= w_hit_next;
      r_mv  <= |w_hit_next;
      if (w_wrap)
        r_idx <= '0;
      else if (!r_mv && (|w_hit_next))
        r_idx <= IW'(lowest_set(w_hit_ext));
    end
  end

  assign match_valid = r_mv;
  assign match_idx   = r_idx;

`ifdef TMUX_PULSE_OUT_EN
  localparam int PCW = $clog2(PULSE_WIDTH + 1);

  logic [NUM_INPUTS-1:0][PCW-1:0] r_pcnt;
  logic [NUM_INPUTS-1:0]          r_pulse;

  // Per-channel pulse: starts on the new match, ends after PULSE_WIDTH clocks or at the boundary.
  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      r_pcnt  <= '0;
      r_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (w_wrap) begin
          r_pulse[i] <= 1'b0;
          r_pcnt[i]  <= '0;
        end else if (w_hit_next[i] && !r_hit[i]) begin
          r_pulse[i] <= 1'b1;
          r_pcnt[i]  <= PCW'(1);
        end else if (r_pulse[i]) begin
          if (r_pcnt[i] == PCW'(PULSE_WIDTH))
            r_pulse[i] <= 1'b0;
          else
            r_pcnt[i] <= r_pcnt[i] + 1'b1;
        end
      end
    end
  end

  assign y = r_pulse;
`else
  assign y = r_hit;
`endif

endmodule

// File: tb/tb_temporal_mux_n.sv
// Scoreboard bench for temporal_mux_n (NUM_INPUTS=4, GAMMA_CYCLE_WIDTH=16).
module tb_temporal_mux_n;

  localparam int N  = 4;
  localparam int GW = 16;
  localparam int PW = 8;

  logic         clk = 1'b0;
  logic         grst;
  logic [N-1:0] inputs;
  logic         select_line;
  logic [N-1:0] y;
  logic         match_valid;
  logic [1:0]   match_idx;
  logic         gamma_start;

  typedef struct packed {
    logic [N-1:0] y;
    logic         mv;
    logic [1:0]   idx;
    logic         gs;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  temporal_mux_n #(.NUM_INPUTS(N), .GAMMA_CYCLE_WIDTH(GW), .PULSE_WIDTH(PW)) dut (
    .clk         (clk),
    .grst        (grst),
    .inputs      (inputs),
    .select_line (select_line),
    .y           (y),
    .match_valid (match_valid),
    .match_idx   (match_idx),
    .gamma_start (gamma_start)
  );

  // Monitor: one expected snapshot per clock, checked 2ns after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if ({y, match_valid, match_idx, gamma_start} !== e) begin
          n_bad++;
          $display("FAIL vec%0d got y=%b mv=%b idx=%0d gs=%b want y=%b mv=%b idx=%0d gs=%b",
                   n_vec, y, match_valid, match_idx, gamma_start, e.y, e.mv, e.idx, e.gs);
        end
      end
    end
  end

  // Expected outputs while gcnt shows d (d==GW stands for gcnt 0 of the next cycle).
  function automatic exp_t expv(input int d, input logic [N-1:0] m, input int from, input int ix);
    exp_t e;
    int   pend;
    logic on;
`ifdef TMUX_PULSE_OUT_EN
    pend = from + PW - 1;
`else
    pend = GW - 1;
`endif
    e = '0;
    if (d >= GW) begin
      e.gs = 1'b1;
    end else begin
      on   = (m != '0) && (d >= from);
      e.y  = (on && d <= pend) ? m : '0;
      e.mv = on;
      e.idx = on ? ix[1:0] : 2'd0;
    end
    return e;
  endfunction

  // Drive one gamma cycle (ngs clocks from gcnt 0); tN = gcnt of the one-clock pulse, 99 = never.
  task automatic run_cycle(input int t0, input int t1, input int t2, input int t3, input int ts,
                           input logic [N-1:0] m, input int from, input int ix, input int ngs);
    for (int g = 0; g < ngs; g++) begin
      @(negedge clk);
      inputs      = {t3 == g, t2 == g, t1 == g, t0 == g};
      select_line = (ts == g);
      q.push_back(expv(g + 1, m, from, ix));
    end
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if ({y, match_valid, match_idx, gamma_start} !== '0) begin
      n_bad++;
      $display("FAIL %s got y=%b mv=%b idx=%0d gs=%b want all zero",
               name, y, match_valid, match_idx, gamma_start);
    end
  endtask

  initial begin
    grst        = 1'b1;
    inputs      = '0;
    select_line = 1'b0;
    #12;
    check_zero("reset_state");
    @(negedge clk);
    grst = 1'b0;
    q.push_back(expv(GW, '0, 0, 0));

    run_cycle( 3,  5,  7,  9,  5, 4'b0010,  7, 1, GW);  // one channel matches select
    run_cycle( 3,  5,  7,  9,  6, 4'b0000,  0, 0, GW);  // select with no partner
    run_cycle(99,  4, 99,  4,  4, 4'b1010,  6, 1, GW);  // simultaneous matches
    run_cycle(99, 99, 14, 99, 14, 4'b0000,  0, 0, GW);  // too late, discarded
    run_cycle(99, 99,  0, 99,  0, 4'b0100,  2, 2, GW);  // match at gcnt 0
    run_cycle(99, 99, 99, 99, 99, 4'b0000,  0, 0, GW);  // never == never
    run_cycle(10, 99, 99, 99, 10, 4'b0001, 12, 0, GW);  // late match, truncated pulse
    run_cycle( 2, 99, 99,  2,  2, 4'b1001,  4, 0, GW);  // early match, full pulse

    // Reset in mid-cycle while a match is showing.
    run_cycle( 4, 99, 99, 99,  4, 4'b0001,  6, 0, 6);
    @(negedge clk);
    inputs      = '0;
    select_line = 1'b0;
    grst        = 1'b1;
    #1;
    check_zero("midcycle_reset");
    @(negedge clk);
    grst = 1'b0;
    q.push_back(expv(GW, '0, 0, 0));
    run_cycle(99, 99, 99, 99,  4, 4'b0000,  0, 0, GW);  // old ch0 arrival is gone

    for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
